// File: rtl/store_alignment_unit.sv
// store_alignment_unit
// Write-side store aligner between the core store path and the data memory port.
// It takes one SB/SH/SW request with a byte address and right-justified data.
// It emits word-aligned write beats with lane-shifted data and byte strobes.
// Optional build macro: MISALIGNED_STORE_SPLIT_EN
//   defined   : a store that crosses a word boundary is split into two beats.
//   undefined : a store that crosses a word boundary is rejected with an err pulse.
module store_alignment_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            STOREop,
  input  logic [31:0]           req_wdata,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  output logic                  done,
  output logic                  err
);

`ifdef MISALIGNED_STORE_SPLIT_EN
  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_BEAT0} state_t;
`endif

  state_t                r_state;
  logic                  r_req_ready;
  logic                  r_mem_valid;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic [3:0]            r_mem_wstrb;
  logic                  r_done;
  logic                  r_err;

`ifdef MISALIGNED_STORE_SPLIT_EN
  logic                  r_split;
  logic [31:0]           r_hi_wdata;
  logic [3:0]            r_hi_wstrb;
  logic [63:0]           w_data_sh;
`endif

  logic [3:0]            w_mask;
  logic [31:0]           w_data_masked;
  logic [1:0]            w_off;
  logic [7:0]            w_strb_sh;
  logic [31:0]           w_lo_wdata;
  logic                  w_misaligned;
  logic                  w_illegal;
  logic                  w_reject;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_beat0_addr;

  // Byte-size mask from the store type; illegal op enables no lanes
  always_comb begin
    w_mask = 4'b0000;
    case (STOREop)
      2'b00:   w_mask = 4'b0001;
      2'b01:   w_mask = 4'b0011;
      2'b10:   w_mask = 4'b1111;
      default: w_mask = 4'b0000;
    endcase
  end

  // Zero every data byte outside the store size before lane shifting
  always_comb begin
    w_data_masked = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_data_masked[8*i +: 8] = w_mask[i] ? req_wdata[8*i +: 8] : 8'h00;
    end
  end

  assign w_off     = req_addr[1:0];
  assign w_strb_sh = {4'b0000, w_mask} << w_off;

`ifdef MISALIGNED_STORE_SPLIT_EN
  assign w_data_sh  = {32'h0, w_data_masked} << {w_off, 3'b000};
  assign w_lo_wdata = w_data_sh[31:0];
`else
  // Only the low word is ever driven, so a 32-bit shift suffices here
  assign w_lo_wdata = w_data_masked << {w_off, 3'b000};
`endif

  assign w_misaligned = |w_strb_sh[7:4];
  assign w_illegal    = (STOREop == 2'b11);
`ifdef MISALIGNED_STORE_SPLIT_EN
  assign w_reject     = w_illegal;
`else
  assign w_reject     = w_illegal | w_misaligned;
`endif
  assign w_accept     = req_valid & r_req_ready;
  assign w_beat0_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};

  // Control FSM with registered handshake, beat and status outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef MISALIGNED_STORE_SPLIT_EN
      r_split     <= 1'b0;
      r_hi_wdata  <= '0;
      r_hi_wstrb  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_reject) begin
              r_err <= 1'b1;
            end else begin
              r_state     <= S_BEAT0;
              r_req_ready <= 1'b0;
              r_mem_valid <= 1'b1;
              r_mem_addr  <= w_beat0_addr;
              r_mem_wdata <= w_lo_wdata;
              r_mem_wstrb <= w_strb_sh[3:0];
`ifdef MISALIGNED_STORE_SPLIT_EN
              r_split     <= w_misaligned;
              r_hi_wdata  <= w_data_sh[63:32];
              r_hi_wstrb  <= w_strb_sh[7:4];
`endif
            end
          end
        end
        S_BEAT0: begin
          if (mem_ready) begin
`ifdef MISALIGNED_STORE_SPLIT_EN
            if (r_split) begin
              r_state     <= S_BEAT1;
              r_mem_addr  <= r_mem_addr + ADDR_WIDTH'(4);
              r_mem_wdata <= r_hi_wdata;
              r_mem_wstrb <= r_hi_wstrb;
            end else begin
              r_state     <= S_IDLE;
              r_req_ready <= 1'b1;
              r_mem_valid <= 1'b0;
              r_mem_addr  <= '0;
              r_mem_wdata <= '0;
              r_mem_wstrb <= '0;
              r_done      <= 1'b1;
            end
`else
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_done      <= 1'b1;
`endif
          end
        end
`ifdef MISALIGNED_STORE_SPLIT_EN
        S_BEAT1: begin
          if (mem_ready) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_split     <= 1'b0;
            r_done      <= 1'b1;
          end
        end
`endif
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_mem_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_store_alignment_unit.sv
// Directed bench for store_alignment_unit; follows MISALIGNED_STORE_SPLIT_EN.
module tb_store_alignment_unit;
  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  STOREop;
  logic [31:0] req_wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  store_alignment_unit #(.ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .STOREop   (STOREop),
    .req_wdata (req_wdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .done      (done),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    chk({tag, "_valid"}, 64'(mem_valid), 64'd1);
    chk({tag, "_addr"},  64'(mem_addr),  64'(a));
    chk({tag, "_strb"},  64'(mem_wstrb), 64'(s));
    chk({tag, "_data"},  64'(mem_wdata), 64'(d));
  endtask

  task automatic idle_after(input string tag, input logic exp_done, input logic exp_err);
    chk({tag, "_done"},  64'(done),      64'(exp_done));
    chk({tag, "_err"},   64'(err),       64'(exp_err));
    chk({tag, "_mvld"},  64'(mem_valid), 64'd0);
    chk({tag, "_rdy"},   64'(req_ready), 64'd1);
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] op, input logic [31:0] d);
    req_valid = 1'b1;
    req_addr  = a;
    STOREop   = op;
    req_wdata = d;
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_addr = '0; STOREop = '0;
    req_wdata = '0; mem_ready = 1'b0;
    #12;
    chk("rst_rdy",  64'(req_ready), 64'd1);
    chk("rst_mvld", 64'(mem_valid), 64'd0);
    chk("rst_addr", 64'(mem_addr),  64'd0);
    chk("rst_data", 64'(mem_wdata), 64'd0);
    chk("rst_strb", 64'(mem_wstrb), 64'd0);
    chk("rst_done", 64'(done),      64'd0);
    chk("rst_err",  64'(err),       64'd0);
    tick();
    resetn = 1'b1;
    tick();

    // SB to byte 3
    mem_ready = 1'b1;
    drive(32'h0000_1003, 2'b00, 32'hAABB_CCDD);
    tick(); req_valid = 1'b0;
    beat("sb", 32'h0000_1000, 4'b1000, 32'hDD00_0000);
    chk("sb_rdy0", 64'(req_ready), 64'd0);
    chk("sb_done0", 64'(done), 64'd0);
    tick();
    idle_after("sb_end", 1'b1, 1'b0);
    tick();
    chk("sb_done_pulse", 64'(done), 64'd0);

    // SH to upper half
    drive(32'h0000_2002, 2'b01, 32'h1234_BEEF);
    tick(); req_valid = 1'b0;
    beat("sh", 32'h0000_2000, 4'b1100, 32'hBEEF_0000);
    chk("sh_err0", 64'(err), 64'd0);
    tick();
    idle_after("sh_end", 1'b1, 1'b0);
    tick();

    // Misaligned SW at offset 1
    drive(32'h0000_3001, 2'b10, 32'h1122_3344);
    tick(); req_valid = 1'b0;
`ifdef MISALIGNED_STORE_SPLIT_EN
    beat("sw_b0", 32'h0000_3000, 4'b1110, 32'h2233_4400);
    tick();
    beat("sw_b1", 32'h0000_3004, 4'b0001, 32'h0000_0011);
    chk("sw_b1_done", 64'(done), 64'd0);
    tick();
    idle_after("sw_end", 1'b1, 1'b0);
`else
    idle_after("sw_rej", 1'b0, 1'b1);
    tick();
    idle_after("sw_rej2", 1'b0, 1'b0);
`endif
    tick();

    // Aligned SW always completes in one beat
    drive(32'h0000_3000, 2'b10, 32'h1122_3344);
    tick(); req_valid = 1'b0;
    beat("swa", 32'h0000_3000, 4'b1111, 32'h1122_3344);
    tick();
    idle_after("swa_end", 1'b1, 1'b0);
    tick();

    // SH at offset 3 crosses the word boundary
    drive(32'h0000_5003, 2'b01, 32'hAAAA_1234);
    tick(); req_valid = 1'b0;
`ifdef MISALIGNED_STORE_SPLIT_EN
    beat("sh3_b0", 32'h0000_5000, 4'b1000, 32'h3400_0000);
    tick();
    beat("sh3_b1", 32'h0000_5004, 4'b0001, 32'h0000_0012);
    tick();
    idle_after("sh3_end", 1'b1, 1'b0);
`else
    idle_after("sh3_rej", 1'b0, 1'b1);
`endif
    tick();

    // Illegal op is rejected in every build
    drive(32'h0000_6000, 2'b11, 32'hFFFF_FFFF);
    tick(); req_valid = 1'b0;
    idle_after("ill", 1'b0, 1'b1);
    tick();
    idle_after("ill2", 1'b0, 1'b0);

    // Stall: beat holds, second request waits for done
    mem_ready = 1'b0;
    drive(32'h0000_4000, 2'b10, 32'hCAFE_F00D);
    tick();
    drive(32'h0000_4005, 2'b00, 32'h0000_0077);
    for (int i = 0; i < 3; i++) begin
      beat("stall", 32'h0000_4000, 4'b1111, 32'hCAFE_F00D);
      chk("stall_rdy", 64'(req_ready), 64'd0);
      chk("stall_done", 64'(done), 64'd0);
      tick();
    end
    beat("stall_last", 32'h0000_4000, 4'b1111, 32'hCAFE_F00D);
    mem_ready = 1'b1;
    tick();
    idle_after("stall_end", 1'b1, 1'b0);
    tick(); req_valid = 1'b0;
    beat("second", 32'h0000_4004, 4'b0010, 32'h0000_7700);
    chk("second_done", 64'(done), 64'd0);
    tick();
    idle_after("second_end", 1'b1, 1'b0);
    tick();

    // Reset mid-operation abandons the store
`ifdef MISALIGNED_STORE_SPLIT_EN
    drive(32'hFFFF_FFFE, 2'b10, 32'hA1B2_C3D4);
    tick(); req_valid = 1'b0;
    beat("wrap_b0", 32'hFFFF_FFFC, 4'b1100, 32'hC3D4_0000);
    tick();
    beat("wrap_b1", 32'h0000_0000, 4'b0011, 32'h0000_A1B2);
`else
    drive(32'hFFFF_FFFE, 2'b10, 32'hA1B2_C3D4);
    tick(); req_valid = 1'b0;
    idle_after("wrap_rej", 1'b0, 1'b1);
    tick();
    mem_ready = 1'b0;
    drive(32'h0000_7000, 2'b10, 32'h0102_0304);
    tick(); req_valid = 1'b0;
    beat("mid_b0", 32'h0000_7000, 4'b1111, 32'h0102_0304);
`endif
    resetn = 1'b0;
    #1;
    chk("mrst_mvld", 64'(mem_valid), 64'd0);
    chk("mrst_rdy",  64'(req_ready), 64'd1);
    chk("mrst_strb", 64'(mem_wstrb), 64'd0);
    chk("mrst_data", 64'(mem_wdata), 64'd0);
    tick();
    chk("mrst_done", 64'(done), 64'd0);
    resetn = 1'b1;
    mem_ready = 1'b1;
    tick();
    idle_after("post_rst", 1'b0, 1'b0);
    tick();
    idle_after("post_rst2", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/store_alignment_unit.md
Name: store_alignment_unit

Overview:
- Write-side counterpart of the load aligner; sits between the core's store path and the data memory/bus port.
- Accepts one store request (SB/SH/SW, byte address, register data).
- Produces word-aligned memory write beats with lane-shifted data and byte strobes over a valid/ready handshake.
- Misaligned stores either split into two beats or are rejected, depending on build (see Optional Feature).

Parameters:
- ADDR_WIDTH, 32, byte-address width of the request address and mem_addr.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- req_valid  input  1  store request present.
- req_ready  output  1  unit can accept a request.
- req_addr  input  ADDR_WIDTH  byte address of the store.
- STOREop  input  2  store type: 2'b00 SB, 2'b01 SH, 2'b10 SW, 2'b11 illegal.
- req_wdata  input  32  register data, right-justified.
- mem_valid  output  1  write beat valid.
- mem_ready  input  1  memory accepts beat.
- mem_addr  output  ADDR_WIDTH  word-aligned beat address (bits [1:0] = 0).
- mem_wdata  output  32  lane-aligned write data.
- mem_wstrb  output  4  byte-lane strobes; bit i covers mem_wdata[8i+7:8i].
- done  output  1  one-cycle pulse: store fully committed.
- err  output  1  one-cycle pulse: store rejected, no memory access.

Behaviour:
- Clock is clk; reset is resetn, asynchronous, active-low.
- Reset values: req_ready=1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, done=0, err=0; FSM=IDLE.
- FSM states: IDLE, BEAT0, BEAT1.
- req_ready is 1 only in IDLE. A request is accepted when req_valid && req_ready; addr, op and data are registered on that edge.
- Size mask: SB=4'b0001, SH=4'b0011, SW=4'b1111. Data bytes outside the size are zeroed before shifting.
- Shifting: off = req_addr[1:0].
  - 64-bit data = {32'b0, masked data} << (8*off).
  - 8-bit strobe = {4'b0, mask} << off.
  - Low halves go to beat 0; high halves go to beat 1.
  - Bytes whose strobe is 0 are driven 0.
- Misaligned: SH with off==3, or SW with off!=0 (i.e. the high strobe half is nonzero).
- IDLE -> BEAT0 on acceptance of a legal request. mem_valid rises the cycle after acceptance.
  - mem_addr = {addr[AW-1:2], 2'b00}.
  - Beat-0 data and strobe as above.
- BEAT0 with mem_ready:
  - Misaligned: go to BEAT1. mem_addr = beat-0 address + 4, wrapping modulo 2^ADDR_WIDTH. Beat-1 data and strobe as above.
  - Otherwise: go to IDLE, mem_valid=0, done=1 the next cycle.
- BEAT1 with mem_ready: go to IDLE, mem_valid=0, done=1 the next cycle.
- While mem_valid=1 and mem_ready=0, mem_addr, mem_wdata and mem_wstrb hold stable and the state holds.
- mem_ready while mem_valid=0 is ignored.
- Rejected request (STOREop 2'b11, or misaligned without split support):
  - Accepted, then err=1 for exactly one cycle (the cycle after acceptance).
  - No mem_valid; state stays IDLE; req_ready stays 1.
- done and err are never high together. A new request may be accepted in the same cycle done or err is high.
- Reset mid-operation: all outputs return to reset values asynchronously; the in-flight store is abandoned. No done or err is issued for it.
- Latency: an aligned store with mem_ready tied high gives done 2 cycles after acceptance. A split store gives done 3 cycles after acceptance.

Optional Feature:
- Macro: MISALIGNED_STORE_SPLIT_EN.
- Defined: misaligned SH/SW are split into two beats (BEAT0 then BEAT1) as above; err fires only for STOREop 2'b11.
- Undefined: BEAT1 state and the beat-1 datapath are not built. Misaligned SH/SW are rejected with an err pulse and no memory access.

Test Plan:
- SB, addr 0x1003, data 0xAABBCCDD, mem_ready=1 -> one beat: mem_addr 0x1000, wstrb 4'b1000, wdata 0xDD000000; done 2 cycles after acceptance.
- SH, addr 0x2002, data 0x1234BEEF -> one beat: mem_addr 0x2000, wstrb 4'b1100, wdata 0xBEEF0000; done pulse; err stays 0.
- SW, addr 0x3001, data 0x11223344, MISALIGNED_STORE_SPLIT_EN defined -> beat 0: 0x3000 / 4'b1110 / 0x22334400; beat 1: 0x3004 / 4'b0001 / 0x00000011; then done.
- Same stimulus with the macro undefined -> err pulse one cycle after acceptance, mem_valid never asserts; SW addr 0x3000 still completes normally.
- SW, addr 0x4000, mem_ready held low 3 cycles, req_valid held high with a second request -> beat outputs stable for all stall cycles; req_ready=0, second request not accepted until after done.
- resetn pulsed low during BEAT1 -> mem_valid drops immediately, no done, req_ready=1 after release. With the macro defined, SW addr 0xFFFFFFFE -> beat 1 mem_addr 0x00000000 (wrap).
